// File: rtl/motor_pwm_ramp_if.sv
// Command/status bundle between a motor_controller and its soft-start PWM stage.
// master drives the run/direction/duty request; slave returns bridge drive and status.
interface motor_pwm_ramp_if;
    logic       EN_IN;
    logic       DIR_IN;
    logic [7:0] DUTY_MAX;
    logic       MOTOR_EN;
    logic       MOTOR_DIR;
    logic [7:0] DUTY;
    logic       BUSY;

    modport master (output EN_IN, DIR_IN, DUTY_MAX,
                    input  MOTOR_EN, MOTOR_DIR, DUTY, BUSY);
    modport slave  (input  EN_IN, DIR_IN, DUTY_MAX,
                    output MOTOR_EN, MOTOR_DIR, DUTY, BUSY);
endinterface

// File: rtl/motor_pwm_ramp.sv
// Soft-start PWM stage: ramps duty linearly toward DUTY_MAX and only flips the
// bridge direction once duty has ramped back to zero and the FSM is idle.
module motor_pwm_ramp #(
    parameter logic [7:0]  PWM_DIV  = 8'd19,
    parameter logic [19:0] RAMP_DIV = 20'd124999
) (
    input  logic            CLK,
    input  logic            RST,
    motor_pwm_ramp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t      state, state_nxt;
    logic [7:0]  presc, pwm_cnt, act_duty;
    logic [7:0]  duty_q, duty_nxt, target;
    logic [19:0] ramp_cnt;
    logic        dir_q, dir_nxt, motor_en_q;
    logic        presc_wrap, pwm_wrap, step;

    // A direction mismatch means a reversal is pending: drive duty to zero first.
    assign target     = (bus.EN_IN && (bus.DIR_IN == dir_q)) ? bus.DUTY_MAX : 8'd0;
    assign presc_wrap = (presc == PWM_DIV);
    assign pwm_wrap   = presc_wrap && (pwm_cnt == 8'hff);
    assign step       = (state == RAMP) && (ramp_cnt == RAMP_DIV);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc   <= 8'd0;
            pwm_cnt <= 8'd0;
        end else if (presc_wrap) begin
            presc   <= 8'd0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc   <= presc + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ramp_cnt <= 20'd0;
        else if ((state != RAMP) || step)
            ramp_cnt <= 20'd0;
        else
            ramp_cnt <= ramp_cnt + 20'd1;
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_q;
        dir_nxt   = dir_q;
        case (state)
            IDLE: begin
                duty_nxt = 8'd0;
                if (bus.EN_IN && (bus.DUTY_MAX != 8'd0)) begin
                    dir_nxt   = bus.DIR_IN;
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (step && (duty_q != target))
                    duty_nxt = (duty_q < target) ? duty_q + 8'd1 : duty_q - 8'd1;
                // Settling also covers a target that moved onto DUTY between steps.
                if (duty_nxt == target)
                    state_nxt = (target == 8'd0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (target != duty_q)
                    state_nxt = RAMP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            duty_q     <= 8'd0;
            dir_q      <= 1'b0;
            act_duty   <= 8'd0;
            motor_en_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            duty_q     <= duty_nxt;
            dir_q      <= dir_nxt;
            // Active duty only changes on a period boundary so no period is truncated.
            if (state == IDLE)
                act_duty <= 8'd0;
            else if (pwm_wrap)
                act_duty <= duty_q;
            motor_en_q <= (state != IDLE) && (act_duty > pwm_cnt);
        end
    end

    assign bus.MOTOR_EN  = motor_en_q;
    assign bus.MOTOR_DIR = dir_q;
    assign bus.DUTY      = duty_q;
    assign bus.BUSY      = (state != IDLE);
endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp: directed vector table, hand sequences for period
// boundary and async reset, then random stimulus against a behavioural model.
module tb_motor_pwm_ramp;
    localparam int P = 0;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;
    int   cyc;

    motor_pwm_ramp_if bus ();

    motor_pwm_ramp #(.PWM_DIV(8'd0), .RAMP_DIV(20'd3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0; else cyc <= cyc + 1;

    // Reference model: pwm position from elapsed clocks, duty steps from clocks spent ramping.
    int m_n, m_duty, m_act, m_age, m_tgt, m_nd;
    bit m_run, m_ramp, m_dir, m_en, m_bnd;

    always_comb begin
        m_tgt = (bus.EN_IN && (bus.DIR_IN == m_dir)) ? int'(bus.DUTY_MAX) : 0;
        m_bnd = ((m_n + 1) % (256 * (P + 1))) == 0;
        m_nd  = m_duty;
        if (((m_age + 1) % (R + 1)) == 0) begin
            if (m_tgt > m_duty) m_nd = m_duty + 1;
            else if (m_tgt < m_duty) m_nd = m_duty - 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0; m_run <= 0; m_ramp <= 0; m_dir <= 0;
            m_en <= 0; m_duty <= 0; m_act <= 0; m_age <= 0;
        end else begin
            m_n  <= m_n + 1;
            m_en <= m_run && (m_act > ((m_n / (P + 1)) % 256));
            if (!m_run) begin
                m_duty <= 0;
                m_act  <= 0;
                if (bus.EN_IN && bus.DUTY_MAX != 8'd0) begin
                    m_dir <= bus.DIR_IN; m_run <= 1; m_ramp <= 1; m_age <= 0;
                end
            end else begin
                if (m_bnd) m_act <= m_duty;
                if (m_ramp) begin
                    m_duty <= m_nd;
                    m_age  <= m_age + 1;
                    if (m_nd == m_tgt) begin
                        m_ramp <= 0;
                        m_run  <= (m_tgt != 0);
                    end
                end else if (m_tgt != m_duty) begin
                    m_ramp <= 1;
                    m_age  <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_chk++;
            if ({bus.DUTY, bus.MOTOR_EN, bus.MOTOR_DIR, bus.BUSY} !==
                {m_duty[7:0], m_en, m_dir, m_run}) begin
                n_fail++;
                if (n_fail <= 10)
                    $display("FAIL model cyc%0d: got duty=%0d en=%b dir=%b busy=%b expected duty=%0d en=%b dir=%b busy=%b",
                             cyc, bus.DUTY, bus.MOTOR_EN, bus.MOTOR_DIR, bus.BUSY, m_duty, m_en, m_dir, m_run);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input bit en, input bit dir, input logic [7:0] dmax);
        bus.EN_IN = en; bus.DIR_IN = dir; bus.DUTY_MAX = dmax;
    endtask

    typedef struct {
        bit         en, dir;
        logic [7:0] dmax;
        int         wait_n;
        int         e_duty;
        bit         e_dir, e_busy, chk_en, e_en;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int exp_d, hi, r;
        bit changed;
        drive(0, 0, 8'd0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset duty", bus.DUTY, 0);
        chk("reset en", bus.MOTOR_EN, 0);
        chk("reset dir", bus.MOTOR_DIR, 0);
        chk("reset busy", bus.BUSY, 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // ramp up, reversal, retarget, ramp to zero, zero-max request
        tbl.push_back('{1, 1, 8'd8,  1,  0, 1, 1, 0, 0});
        tbl.push_back('{1, 1, 8'd8,  3,  0, 1, 1, 0, 0});
        tbl.push_back('{1, 1, 8'd8,  1,  1, 1, 1, 0, 0});
        tbl.push_back('{1, 1, 8'd8,  4,  2, 1, 1, 0, 0});
        tbl.push_back('{1, 1, 8'd8,  24, 8, 1, 1, 0, 0});
        tbl.push_back('{1, 1, 8'd8,  4,  8, 1, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd8,  1,  8, 1, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd8,  31, 1, 1, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd8,  1,  0, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 8'd8,  1,  0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 8'd8,  32, 8, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd4,  5,  7, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd4,  4,  6, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd4,  4,  5, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd4,  4,  4, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 8'd4,  8,  4, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 8'd4,  17, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 8'd0,  1024, 0, 0, 0, 1, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].dir, tbl[i].dmax);
            repeat (tbl[i].wait_n) @(negedge clk);
            chk($sformatf("vec%0d duty", i), bus.DUTY, tbl[i].e_duty);
            chk($sformatf("vec%0d dir", i), bus.MOTOR_DIR, tbl[i].e_dir);
            chk($sformatf("vec%0d busy", i), bus.BUSY, tbl[i].e_busy);
            if (tbl[i].chk_en) chk($sformatf("vec%0d en", i), bus.MOTOR_EN, tbl[i].e_en);
        end

        // PWM high time per period follows the duty latched at the period start.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 8'd200);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 256 && (cyc % 256) != 255; k++) @(negedge clk);
            exp_d = (cyc - 1) / 4;
            if (exp_d > 200) exp_d = 200;
            chk($sformatf("period%0d latched duty", p), bus.DUTY, exp_d);
            @(negedge clk);
            hi = 0;
            changed = 0;
            repeat (256) begin
                @(negedge clk);
                hi += int'(bus.MOTOR_EN);
                if (bus.DUTY != exp_d[7:0]) changed = 1;
            end
            chk($sformatf("period%0d high time", p), hi, exp_d);
            chk($sformatf("period%0d mid-period change", p), changed, (exp_d < 200) ? 1 : 0);
        end
        repeat (2) @(negedge clk);
        chk("run en high", bus.MOTOR_EN, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst en", bus.MOTOR_EN, 0);
        chk("async rst busy", bus.BUSY, 0);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-ramp at duty 5, then restart from zero
        drive(1, 1, 8'd8);
        repeat (21) @(negedge clk);
        chk("midramp duty", bus.DUTY, 5);
        #2 rst = 1'b1;
        #1;
        chk("rst6 duty", bus.DUTY, 0);
        chk("rst6 dir", bus.MOTOR_DIR, 0);
        chk("rst6 busy", bus.BUSY, 0);
        chk("rst6 en", bus.MOTOR_EN, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart busy", bus.BUSY, 1);
        chk("restart duty", bus.DUTY, 0);
        repeat (4) @(negedge clk);
        chk("restart step1", bus.DUTY, 1);

        // random traffic checked cycle by cycle against the model
        for (int c = 0; c < 20000; c++) begin
            r = int'($urandom_range(0, 63));
            if (r == 0) bus.EN_IN = ~bus.EN_IN;
            else if (r == 1) bus.DIR_IN = ~bus.DIR_IN;
            else if (r == 2) bus.DUTY_MAX = 8'($urandom_range(0, 15));
            else if (r == 3 && $urandom_range(0, 7) == 0) bus.DUTY_MAX = 8'd255;
            if (c == 10000) rst = 1'b1;
            if (c == 10001) rst = 1'b0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
